// File: rtl/pio_update_arbiter.sv
// pio_update_arbiter
//
// Round-robin arbiter sharing one output PIO register (Avalon-MM slave, data at
// offset 0) among N_REQ requesters. Each grant issues exactly one single-cycle
// write, then the block stays busy for HOLD_CYCLES idle cycles before it
// arbitrates again.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   req            per-requester update request (level, held until ack)
//   req_data       requester i value at [i*DATA_W +: DATA_W]
//   ack            one-cycle pulse to the granted requester, with the write
//   avm_address    PIO address, constant 0
//   avm_chipselect PIO chipselect
//   avm_write_n    PIO write strobe, active low
//   avm_writedata  zero-extended granted value
//   busy           high in WRITE and HOLD
//   last_grant     index of the most recent grant
//
// Optional (macro PIO_UPDATE_ARB_STATS_EN):
//   write_count    16-bit wrapping count of writes issued
//   starve_flag    sticky flag: some req waited more than 4*N_REQ*(HOLD_CYCLES+2)
//                  consecutive cycles without an ack

module pio_update_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned HOLD_CYCLES = 2,
    localparam int unsigned PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic [1:0]                avm_address,
    output logic                      avm_chipselect,
    output logic                      avm_write_n,
    output logic [31:0]               avm_writedata,
    output logic                      busy,
    output logic [PTR_W-1:0]          last_grant
`ifdef PIO_UPDATE_ARB_STATS_EN
    ,
    output logic [15:0]               write_count,
    output logic                      starve_flag
`endif
);

    typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   last_grant_q, last_grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic               cs_q, cs_d;
    logic               wn_q, wn_d;
    logic [31:0]        wd_q, wd_d;
    logic               busy_q, busy_d;

    logic [PTR_W-1:0]   win;
    logic [DATA_W-1:0]  win_data;
    logic [31:0]        win_data_ext;
    logic               found;
    int unsigned        idx;

    // Search upward from the pointer, wrapping, for the first pending request.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = 32'(ptr_q) + 32'(k);
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                win   = idx[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (32'(win) == 32'(i)) win_data = req_data[i*DATA_W +: DATA_W];
        end
        win_data_ext = '0;
        win_data_ext[DATA_W-1:0] = win_data;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        last_grant_d = last_grant_q;
        ack_d        = '0;
        cs_d         = 1'b0;
        wn_d         = 1'b1;
        wd_d         = wd_q;
        busy_d       = busy_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d      = StWrite;
                    last_grant_d = win;
                    // Pointer remembers the slot after the winner.
                    if (32'(win) == N_REQ - 1) ptr_d = '0;
                    else                       ptr_d = win + PTR_W'(1);
                    ack_d[win]   = 1'b1;
                    cs_d         = 1'b1;
                    wn_d         = 1'b0;
                    wd_d         = win_data_ext;
                    busy_d       = 1'b1;
                end
            end
            StWrite: begin
                if (HOLD_CYCLES == 0) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d   = 8'(HOLD_CYCLES);
                    state_d = StHold;
                end
            end
            StHold: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ptr_q        <= '0;
            last_grant_q <= '0;
            ack_q        <= '0;
            cs_q         <= 1'b0;
            wn_q         <= 1'b1;
            wd_q         <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ptr_q        <= ptr_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            cs_q         <= cs_d;
            wn_q         <= wn_d;
            wd_q         <= wd_d;
            busy_q       <= busy_d;
        end
    end

    assign ack            = ack_q;
    assign avm_address    = 2'b00;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = wd_q;
    assign busy           = busy_q;
    assign last_grant     = last_grant_q;

`ifdef PIO_UPDATE_ARB_STATS_EN
    localparam int unsigned STARVE_LIMIT = 4 * N_REQ * (HOLD_CYCLES + 2);
    localparam int unsigned STARVE_W     = $clog2(STARVE_LIMIT + 2);

    logic [15:0]                      write_count_q;
    logic                             starve_q;
    logic [N_REQ-1:0][STARVE_W-1:0]   wait_cnt_q;
    logic [N_REQ-1:0]                 starve_hit;

    // wait_cnt holds the number of earlier consecutive waiting cycles, so a hit
    // marks the (STARVE_LIMIT+1)-th waiting cycle.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            starve_hit[i] = req[i] && !ack_q[i] && (32'(wait_cnt_q[i]) >= STARVE_LIMIT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_count_q <= '0;
            starve_q      <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            if (state_q == StWrite) write_count_q <= write_count_q + 16'd1;
            for (int i = 0; i < N_REQ; i++) begin
                if (req[i] && !ack_q[i]) begin
                    if (!starve_hit[i]) wait_cnt_q[i] <= wait_cnt_q[i] + STARVE_W'(1);
                end else begin
                    wait_cnt_q[i] <= '0;
                end
            end
            if (|starve_hit) starve_q <= 1'b1;
        end
    end

    assign write_count = write_count_q;
    assign starve_flag = starve_q;
`endif

endmodule
